// File: rtl/tone_period_meter.sv
// Square-wave tone meter: reports period and high time between accepted rising edges,
// plus silence detection and a window match against a reference note period.
module tone_period_meter #(
  parameter int CNT_W         = 26,
  parameter int MIN_PERIOD    = 1000,
  parameter int MAX_PERIOD    = 2_500_000,
  parameter int TARGET_PERIOD = 120002,
  parameter int TOLERANCE     = 600
) (
  input  logic             clk_50MHz,
  input  logic             reset_button_n,
  input  logic             tone_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             period_valid,
  output logic             tone_present,
  output logic             tone_match,
  output logic             glitch_err
);

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] TGT_C = CNT_W'(TARGET_PERIOD);
  localparam logic [CNT_W-1:0] TOL_C = CNT_W'(TOLERANCE);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] ctr_q, ctr_d;
  logic [CNT_W-1:0] high_cap_q, high_cap_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             pv_q, pv_d;
  logic             present_q, present_d;
  logic             match_q, match_d;
  logic             glitch_q, glitch_d;

  logic             rise, fall, accept, timeout;
  logic [CNT_W-1:0] diff;

  assign rise    = s2_q & ~s3_q;
  assign fall    = ~s2_q & s3_q;
  assign accept  = rise && (ctr_q >= MIN_C);
  assign timeout = (ctr_q == MAX_C);
  // Absolute distance from the target, ordered so the subtraction never wraps
  assign diff    = (ctr_q >= TGT_C) ? (ctr_q - TGT_C) : (TGT_C - ctr_q);

  always_ff @(posedge clk_50MHz or negedge reset_button_n) begin
    if (!reset_button_n) begin
      state_q    <= IDLE;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      ctr_q      <= '0;
      high_cap_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      pv_q       <= 1'b0;
      present_q  <= 1'b0;
      match_q    <= 1'b0;
      glitch_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= tone_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      ctr_q      <= ctr_d;
      high_cap_q <= high_cap_d;
      period_q   <= period_d;
      high_q     <= high_d;
      pv_q       <= pv_d;
      present_q  <= present_d;
      match_q    <= match_d;
      glitch_q   <= glitch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise) state_d = MEASURE;
      MEASURE: if (!accept && timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctr_d      = ctr_q;
    high_cap_d = high_cap_q;
    period_d   = period_q;
    high_d     = high_q;
    pv_d       = 1'b0;
    present_d  = present_q;
    match_d    = match_q;
    glitch_d   = 1'b0;
    case (state_q)
      IDLE: begin
        ctr_d = '0;
        if (rise) begin
          ctr_d      = CNT_W'(1);
          high_cap_d = '0;
        end
      end
      MEASURE: begin
        ctr_d = ctr_q + CNT_W'(1);
        if (fall) high_cap_d = ctr_q;
        if (accept) begin
          period_d   = ctr_q;
          high_d     = high_cap_q;
          pv_d       = 1'b1;
          present_d  = 1'b1;
          match_d    = (diff <= TOL_C);
          ctr_d      = CNT_W'(1);
          high_cap_d = '0;
        end else if (rise) begin
          glitch_d = 1'b1;
        end else if (timeout) begin
          // Silence: drop status, keep the last measured period visible
          present_d = 1'b0;
          match_d   = 1'b0;
          ctr_d     = '0;
        end
      end
      default: ctr_d = '0;
    endcase
  end

  assign period_out   = period_q;
  assign high_out     = high_q;
  assign period_valid = pv_q;
  assign tone_present = present_q;
  assign tone_match   = match_q;
  assign glitch_err   = glitch_q;

endmodule
